// File: rtl/cr_kme_word_unpacker.sv
// Word-to-beat unpacker. Pops one wide word from an upstream FIFO read port
// and emits it as NBEATS narrower beats, most-significant beat first.
// The next word is fetched on the final beat, so back-to-back words have no bubble.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no word held; pops in_data as soon as in_valid is high
// HOLD  | word held in hold_q; beat idx_q is presented on out_data
module cr_kme_word_unpacker #(
   parameter int DATA_SIZE = 128,
   parameter int BEAT_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ack,
   output logic [BEAT_SIZE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [15:0]          word_cnt,
   output logic                 ack_err
);

   localparam int NBEATS = DATA_SIZE / BEAT_SIZE;
   // A single-beat configuration still needs a 1-bit index to stay legal.
   localparam int IDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t               state_q;
   logic [DATA_SIZE-1:0] hold_q;
   logic [IDX_W-1:0]     idx_q;
   logic [15:0]          word_cnt_q;
   logic                 ack_err_q;
   logic                 in_valid_q;
   logic                 in_ack_q;

   logic                 accept;
   logic                 at_last;
   logic                 load;
   logic                 ack_err_d;
   logic [DATA_SIZE-1:0] shifted;

   assign accept  = (state_q == HOLD) & out_ready;
   assign at_last = (idx_q == LAST_IDX);
   // Reset gates the pop so a word offered during reset is left in the FIFO.
   assign load    = ~rst & in_valid & ((state_q == EMPTY) | (accept & at_last));
   assign in_ack  = load;

   // Upstream retracted valid without having been popped.
   assign ack_err_d = in_valid_q & ~in_ack_q & ~in_valid;

   // Shifting the held word left brings beat idx_q to the top slice.
   assign shifted   = hold_q << (int'(idx_q) * BEAT_SIZE);
   assign out_valid = (state_q == HOLD);
   assign out_data  = out_valid ? shifted[DATA_SIZE-1 -: BEAT_SIZE] : '0;
   assign out_last  = out_valid & at_last;
   assign word_cnt  = word_cnt_q;
   assign ack_err   = ack_err_q;

   // State machine, holding register, beat index, word counter and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         hold_q     <= '0;
         idx_q      <= '0;
         word_cnt_q <= '0;
         ack_err_q  <= 1'b0;
         in_valid_q <= 1'b0;
         in_ack_q   <= 1'b0;
      end else begin
         in_valid_q <= in_valid;
         in_ack_q   <= load;
         if (ack_err_d) begin
            ack_err_q <= 1'b1;
         end
         if (accept & at_last) begin
            word_cnt_q <= word_cnt_q + 16'd1;
         end
         if (load) begin
            hold_q  <= in_data;
            idx_q   <= '0;
            state_q <= HOLD;
         end else if (accept) begin
            if (at_last) begin
               state_q <= EMPTY;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cr_kme_word_unpacker.sv
// Bench for cr_kme_word_unpacker: a source queue of table words feeds the
// upstream port, expected beats go into a scoreboard when a word is popped,
// and the monitor compares them as beats are accepted.
module tb_cr_kme_word_unpacker;

   logic         clk;
   logic         rst;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_ack;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic [15:0]  word_cnt;
   logic         ack_err;

   // Single-beat instance used for the counter wrap run.
   logic         w_rst;
   logic [31:0]  w_in_data;
   logic         w_in_valid;
   logic         w_in_ack;
   logic [31:0]  w_out_data;
   logic         w_out_valid;
   logic         w_out_ready;
   logic         w_out_last;
   logic [15:0]  w_word_cnt;
   logic         w_ack_err;

   cr_kme_word_unpacker #(.DATA_SIZE(128), .BEAT_SIZE(32)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .word_cnt(word_cnt), .ack_err(ack_err)
   );

   cr_kme_word_unpacker #(.DATA_SIZE(32), .BEAT_SIZE(32)) u_wrap (
      .clk(clk), .rst(w_rst), .in_data(w_in_data), .in_valid(w_in_valid), .in_ack(w_in_ack),
      .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_last(w_out_last), .word_cnt(w_word_cnt), .ack_err(w_ack_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [127:0] data;
      logic [31:0]  b[4];
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        last;
   } exp_t;

   vec_t vec[5];
   int   src[$];
   exp_t sb[$];

   int   checks = 0;
   int   errors = 0;
   bit   drv_en = 1'b1;

   logic        o_valid, o_ack, o_last, o_err;
   logic [31:0] o_data;
   logic [15:0] o_wcnt;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present the head of the source queue on the upstream port.
   task automatic drive();
      if (drv_en) begin
         in_valid = (src.size() > 0);
         in_data  = (src.size() > 0) ? vec[src[0]].data : 128'd0;
      end
   endtask

   // One clock: observe and score at negedge, then update inputs after posedge.
   task automatic step();
      int   idx;
      exp_t e;
      @(negedge clk);
      o_valid = out_valid;
      o_ack   = in_ack;
      o_last  = out_last;
      o_data  = out_data;
      o_wcnt  = word_cnt;
      o_err   = ack_err;
      if (in_ack) begin
         chk("ack_implies_valid", in_valid, 1'b1);
      end
      if (in_valid && in_ack && src.size() > 0) begin
         idx = src.pop_front();
         for (int k = 0; k < 4; k++) begin
            e.d    = vec[idx].b[k];
            e.last = (k == 3);
            sb.push_back(e);
         end
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 1'b1, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_last", out_last, e.last);
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((src.size() > 0 || sb.size() > 0 || out_valid) && n < max_cyc) begin
         step();
         n++;
      end
      if (n >= max_cyc) begin
         chk("drain_timeout", n, 0);
      end
   endtask

   initial begin
      int          cnt0;
      int          nv;
      int          nal;
      int          nacc;
      bit          hit;

      vec[0].data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      vec[0].b    = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      vec[1].data = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      vec[1].b    = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
      vec[2].data = 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A;
      vec[2].b    = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
      vec[3].data = 128'h00000001_00000002_00000003_00000004;
      vec[3].b    = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
      vec[4].data = 128'h80000000_00000000_00000000_00000001;
      vec[4].b    = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000001};

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      w_rst       = 1'b1;
      w_in_valid  = 1'b1;
      w_in_data   = 32'h12345678;
      w_out_ready = 1'b1;

      // Reset with a word offered: pop must stay suppressed, outputs idle.
      src.push_back(0);
      drive();
      repeat (3) step();
      chk("rst_in_ack", o_ack, 1'b0);
      chk("rst_out_valid", o_valid, 1'b0);
      chk("rst_out_last", o_last, 1'b0);
      chk("rst_out_data", o_data, 32'd0);
      chk("rst_word_cnt", o_wcnt, 16'd0);
      chk("rst_ack_err", o_err, 1'b0);
      chk("rst_sb_empty", sb.size(), 0);

      // Single word: ack in first cycle after reset, four consecutive beats.
      rst = 1'b0;
      step();
      chk("single_first_ack", o_ack, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("single_valid", o_valid, 1'b1);
         chk("single_last", o_last, (k == 3));
         chk("single_no_ack", o_ack, 1'b0);
      end
      step();
      chk("single_empty_after", o_valid, 1'b0);
      chk("single_word_cnt", o_wcnt, 16'd1);

      // Table: each word on its own, full throughput.
      for (int i = 0; i < 5; i++) begin
         cnt0 = word_cnt;
         src.push_back(i);
         drive();
         drain(40);
         chk("tbl_word_cnt", word_cnt, 16'(cnt0 + 1));
      end

      // Back-to-back: three words, twelve beats, no bubble.
      cnt0 = word_cnt;
      src.push_back(1);
      src.push_back(2);
      src.push_back(3);
      drive();
      step();
      chk("b2b_first_ack", o_ack, 1'b1);
      nv  = 0;
      nal = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (o_valid) nv++;
         if (o_ack && o_last) nal++;
      end
      chk("b2b_valid_cycles", nv, 12);
      chk("b2b_acks_on_last", nal, 2);
      drain(40);
      chk("b2b_word_cnt", word_cnt, 16'(cnt0 + 3));

      // Backpressure on beat 2 with the next word already waiting.
      cnt0 = word_cnt;
      src.push_back(1);
      drive();
      step();
      step();
      step();
      out_ready = 1'b0;
      src.push_back(2);
      drive();
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold_data", o_data, vec[1].b[2]);
         chk("bp_valid", o_valid, 1'b1);
         chk("bp_no_ack", o_ack, 1'b0);
      end
      out_ready = 1'b1;
      drain(40);
      chk("bp_word_cnt", word_cnt, 16'(cnt0 + 2));

      // Reset after beat 1 of a word; the queued word then starts from beat 0.
      src.push_back(3);
      src.push_back(4);
      drive();
      step();
      step();
      step();
      out_ready = 1'b0;
      rst       = 1'b1;
      step();
      chk("mid_rst_ack_forced", o_ack, 1'b0);
      sb.delete();
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      chk("mid_rst_out_valid", o_valid, 1'b0);
      chk("mid_rst_word_cnt", o_wcnt, 16'd0);
      chk("mid_rst_reack", o_ack, 1'b1);
      drain(40);
      chk("mid_rst_final_cnt", word_cnt, 16'd1);
      chk("pre_err_clear", ack_err, 1'b0);

      // Upstream retracts valid while the unpacker is stalled.
      src.push_back(0);
      drive();
      step();
      out_ready = 1'b0;
      drv_en    = 1'b0;
      step();
      in_valid  = 1'b1;
      in_data   = vec[1].data;
      step();
      chk("err_no_ack_stalled", o_ack, 1'b0);
      in_valid = 1'b0;
      step();
      step();
      chk("err_set", o_err, 1'b1);
      out_ready = 1'b1;
      drv_en    = 1'b1;
      drain(40);
      chk("err_sticky", ack_err, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("err_cleared", o_err, 1'b0);

      // Counter wrap on the single-beat instance at one word per cycle.
      w_rst = 1'b0;
      nacc  = 0;
      hit   = 1'b0;
      for (int c = 0; c < 70000 && !hit; c++) begin
         @(negedge clk);
         if (w_word_cnt == 16'hFFFF) begin
            hit = 1'b1;
            chk("wrap_words_at_ffff", nacc, 65535);
            chk("wrap_last_beat", w_out_last, 1'b1);
            chk("wrap_data", w_out_data, 32'h12345678);
         end else if (w_out_valid) begin
            nacc++;
         end
      end
      chk("wrap_reached_ffff", hit, 1'b1);
      @(negedge clk);
      chk("wrap_to_zero", w_word_cnt, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
